seq_mult_engine: RTL and testbench

Parametrised sequential multiplier: a WIDTH x WIDTH product is built from (WIDTH/DIGIT)^2 digit partial products, one per clock, using a single DIGIT x DIGIT multiplier.
- Merges control FSM, digit counter, digit select, shifter and accumulator into one block.
- Keeps the start/done/error protocol of the existing multiplier control.
- Sits between a register-mapped operand front end and the result consumer.

---
 rtl/seq_mult_engine.sv | 181 ++++++++++++++++++
 tb/tb_seq_mult_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_engine.sv
// seq_mult_engine: digit-serial WIDTH x WIDTH multiplier.
// One DIGIT x DIGIT partial product is accumulated per clock, so a full
// product takes K*K cycles (K = WIDTH/DIGIT). Control FSM, digit counter,
// digit select, shifter and accumulator are merged in this one block, and the
// start/done/error handshake of the older multiplier control is kept.
//
// Optional build macro: SEQ_MULT_SIGNED_EN
//   When defined, an extra input tc selects two's-complement operands.
//   Magnitudes are multiplied and the result is negated on the final edge.
//
// State table (state_out encoding):
//   state  | meaning
//   IDLE   | 00 - waiting for start, product holds the last result
//   CALC   | 01 - accumulating one partial product per cycle
//   DONE   | 10 - one-cycle result-valid, product holds the final value
//   ERR    | 11 - start seen during CALC/DONE, waiting for a fresh start
module seq_mult_engine #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4,
    localparam int K    = WIDTH / DIGIT,
    localparam int KK   = K * K,
    localparam int CW   = (KK > 1) ? $clog2(KK) : 1
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 tc,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           state_out,
    output logic [CW-1:0]        count
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    localparam logic [1:0] S_ERR  = 2'b11;

    localparam int PW  = 2 * WIDTH;
    localparam int PPW = 2 * DIGIT;

    localparam logic [CW-1:0] LAST_IDX = CW'(KK - 1);
    localparam logic [CW-1:0] K_C      = CW'(K);

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;

    // Operand values as they will be captured on an accepted start.
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;

    // Digit select, partial product and accumulator datapath.
    logic [CW-1:0]    dig_i;
    logic [CW-1:0]    dig_j;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [PPW-1:0]   pp;
    logic [PW-1:0]    pp_sh;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    acc_final;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;
    logic sign_cap;

    // Signed mode multiplies magnitudes; the most negative value maps onto
    // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit operand.
    always_comb begin
        a_cap    = (tc && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_cap    = (tc && b[WIDTH-1]) ? (~b + 1'b1) : b;
        sign_cap = tc & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    assign a_cap = a;
    assign b_cap = b;
`endif

    // Digit indices: the a digit walks fastest, the b digit once per K cycles.
    assign dig_i = count_q % K_C;
    assign dig_j = count_q / K_C;

    assign a_dig = DIGIT'(a_q >> (DIGIT * dig_i));
    assign b_dig = DIGIT'(b_q >> (DIGIT * dig_j));

    assign pp      = PPW'(a_dig) * PPW'(b_dig);
    assign pp_sh   = PW'(pp) << (DIGIT * (dig_i + dig_j));
    assign acc_sum = product_q + pp_sh;

`ifdef SEQ_MULT_SIGNED_EN
    // Sign is applied once, on the last accumulation, modulo 2^(2*WIDTH).
    assign acc_final = sign_q ? (~acc_sum + 1'b1) : acc_sum;
`else
    assign acc_final = acc_sum;
`endif

    // Next-state and datapath update for the merged control/accumulator.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        a_d       = a_q;
        b_d       = b_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    a_d       = a_cap;
                    b_d       = b_cap;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d    = sign_cap;
`endif
                    product_d = '0;
                    count_d   = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (start) begin
                    // Protocol violation: abandon this cycle's accumulation
                    // and freeze product/count for inspection.
                    state_d = S_ERR;
                end else if (count_q == LAST_IDX) begin
                    product_d = acc_final;
                    count_d   = '0;
                    state_d   = S_DONE;
                end else begin
                    product_d = acc_sum;
                    count_d   = count_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = start ? S_ERR : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, accumulator and captured operand registers.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            product_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            product_q <= product_d;
            a_q       <= a_d;
            b_q       <= b_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign product   = product_q;
    assign count     = count_q;
    assign state_out = state_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC);
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_seq_mult_engine.sv
// Testbench for seq_mult_engine: three parameterisations (8/4, 16/4, 8/8),
// a table of known products, hand-written protocol sequences and random
// operands checked against a plain-arithmetic reference.
module tb_seq_mult_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;

    // Instance 0: WIDTH=8, DIGIT=4
    logic        start0;
    logic [7:0]  a0, b0;
    logic [15:0] product0;
    logic        done0, busy0, err0;
    logic [1:0]  st0;
    logic [1:0]  count0;

    // Instance 1: WIDTH=16, DIGIT=4
    logic        start1;
    logic [15:0] a1, b1;
    logic [31:0] product1;
    logic        done1, busy1, err1;
    logic [1:0]  st1;
    logic [3:0]  count1;

    // Instance 2: WIDTH=8, DIGIT=8
    logic        start2;
    logic [7:0]  a2, b2;
    logic [15:0] product2;
    logic        done2, busy2, err2;
    logic [1:0]  st2;
    logic [0:0]  count2;

`ifdef SEQ_MULT_SIGNED_EN
    logic tc0, tc1, tc2;
`endif

    seq_mult_engine #(.WIDTH(8), .DIGIT(4)) u0 (
        .clk(clk), .reset_a(reset_a), .start(start0),
`ifdef SEQ_MULT_SIGNED_EN
        .tc(tc0),
`endif
        .a(a0), .b(b0), .product(product0), .done(done0), .busy(busy0),
        .err(err0), .state_out(st0), .count(count0)
    );

    seq_mult_engine #(.WIDTH(16), .DIGIT(4)) u1 (
        .clk(clk), .reset_a(reset_a), .start(start1),
`ifdef SEQ_MULT_SIGNED_EN
        .tc(tc1),
`endif
        .a(a1), .b(b1), .product(product1), .done(done1), .busy(busy1),
        .err(err1), .state_out(st1), .count(count1)
    );

    seq_mult_engine #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .reset_a(reset_a), .start(start2),
`ifdef SEQ_MULT_SIGNED_EN
        .tc(tc2),
`endif
        .a(a2), .b(b2), .product(product2), .done(done2), .busy(busy2),
        .err(err2), .state_out(st2), .count(count2)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        tc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: ordinary integer multiplication, signed when tc is set.
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic tc);
        int sa, sb;
        if (tc) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        return 16'(sa * sb);
    endfunction

    // Full operation on instance 0: start pulse, 4 CALC cycles, done, back to IDLE.
    task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic tc,
                       input logic [15:0] exp, input string tag);
        string t;
        t = $sformatf("%s a=%0h b=%0h tc=%0d", tag, a, b, tc);
        @(negedge clk);
        start0 = 1'b1;
        a0 = a;
        b0 = b;
`ifdef SEQ_MULT_SIGNED_EN
        tc0 = tc;
`endif
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            chk({t, " busy"}, 64'(busy0), 64'd1);
            chk({t, " count"}, 64'(count0), 64'(n));
            chk({t, " early_done"}, 64'(done0), 64'd0);
        end
        @(negedge clk);
        chk({t, " done"}, 64'(done0), 64'd1);
        chk({t, " state_done"}, 64'(st0), 64'd2);
        chk({t, " product"}, 64'(product0), 64'(exp));
        @(negedge clk);
        chk({t, " done_pulse_end"}, 64'(done0), 64'd0);
        chk({t, " state_idle"}, 64'(st0), 64'd0);
        chk({t, " product_hold"}, 64'(product0), 64'(exp));
    endtask

    // Full operation on instance 1: 16 CALC cycles.
    task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        string t;
        t = $sformatf("w16 a=%0h b=%0h", a, b);
        @(negedge clk);
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk({t, " busy"}, 64'(busy1), 64'd1);
            chk({t, " count"}, 64'(count1), 64'(n));
        end
        @(negedge clk);
        chk({t, " done"}, 64'(done1), 64'd1);
        chk({t, " product"}, 64'(product1), 64'(exp));
        @(negedge clk);
        chk({t, " done_pulse_end"}, 64'(done1), 64'd0);
        chk({t, " product_hold"}, 64'(product1), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic        rtc;

        reset_a = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        tc0 = 1'b0; tc1 = 1'b0; tc2 = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        chk("rst state", 64'(st0), 64'd0);
        chk("rst count", 64'(count0), 64'd0);
        chk("rst product", 64'(product0), 64'd0);
        chk("rst flags", 64'({done0, busy0, err0}), 64'd0);
        chk("rst w16 state", 64'(st1), 64'd0);
        chk("rst k1 state", 64'(st2), 64'd0);
        @(negedge clk);
        reset_a = 1'b1;

        // Known-answer table
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h0C, 8'h0A, 1'b0, 16'h0078});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{8'h01, 8'hFF, 1'b0, 16'h00FF});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
        vecs.push_back('{8'h07, 8'h09, 1'b0, 16'h003F});
        vecs.push_back('{8'hAB, 8'hCD, 1'b0, 16'h88EF});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{8'hFD, 8'h05, 1'b1, 16'hFFF1});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'hFD, 8'h05, 1'b0, 16'h04F1});
        vecs.push_back('{8'h05, 8'hFD, 1'b1, 16'hFFF1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
`endif
        for (int v = 0; v < vecs.size(); v++)
            op0(vecs[v].a, vecs[v].b, vecs[v].tc, vecs[v].exp, "table");

        // Product holds in IDLE while start stays low
        repeat (3) begin
            @(negedge clk);
            chk("idle hold state", 64'(st0), 64'd0);
            chk("idle hold product", 64'(product0), 64'(vecs[vecs.size()-1].exp));
        end

        // start reasserted at count=2 -> ERR with partial product frozen
        @(negedge clk);
        start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("err pre count", 64'(count0), 64'd2);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("err state", 64'(st0), 64'd3);
        chk("err flag", 64'(err0), 64'd1);
        chk("err partial", 64'(product0), 64'h0EF1);
        chk("err count hold", 64'(count0), 64'd2);
        chk("err no done", 64'({done0, busy0}), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("err stay state", 64'(st0), 64'd3);
            chk("err stay flags", 64'({done0, busy0, err0}), 64'd1);
        end
        op0(8'h0C, 8'h0A, 1'b0, 16'h0078, "from_err");

        // Async reset mid-CALC at count=1
        @(negedge clk);
        start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        chk("rstmid pre count", 64'(count0), 64'd1);
        #1 reset_a = 1'b0;
        #1;
        chk("rstmid state", 64'(st0), 64'd0);
        chk("rstmid product", 64'(product0), 64'd0);
        chk("rstmid busy", 64'(busy0), 64'd0);
        chk("rstmid count", 64'(count0), 64'd0);
        @(negedge clk);
        reset_a = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rstmid no done", 64'(done0), 64'd0);
            chk("rstmid idle", 64'(st0), 64'd0);
        end
        op0(8'h07, 8'h09, 1'b0, 16'h003F, "after_rst");

        // start held high into the DONE cycle -> ERR, product kept
        @(negedge clk);
        start0 = 1'b1; a0 = 8'h11; b0 = 8'h11;
        @(negedge clk); start0 = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("done2err done", 64'(done0), 64'd1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("done2err state", 64'(st0), 64'd3);
        chk("done2err product", 64'(product0), 64'h0121);

        // Random operands against the arithmetic reference
        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
`ifdef SEQ_MULT_SIGNED_EN
            rtc = 1'($urandom_range(0, 1));
`else
            rtc = 1'b0;
`endif
            op0(ra, rb, rtc, model8(ra, rb, rtc), "rand");
        end

        // WIDTH=16, DIGIT=4
        op1(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        op1(16'h1234, 16'h0000, 32'h00000000);
        op1(16'h1234, 16'h5678, 32'h0626_0060);

        // WIDTH=DIGIT=8: single CALC cycle, then start in DONE -> ERR
        @(negedge clk);
        start2 = 1'b1; a2 = 8'd200; b2 = 8'd3;
        @(negedge clk);
        start2 = 1'b0;
        chk("k1 busy", 64'(busy2), 64'd1);
        chk("k1 count", 64'(count2), 64'd0);
        @(negedge clk);
        chk("k1 done", 64'(done2), 64'd1);
        chk("k1 product", 64'(product2), 64'd600);
        chk("k1 count after", 64'(count2), 64'd0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("k1 err state", 64'(st2), 64'd3);
        chk("k1 err product", 64'(product2), 64'd600);
        chk("k1 err no done", 64'(done2), 64'd0);
        start2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF;
        @(negedge clk);
        start2 = 1'b0;
        chk("k1 restart busy", 64'(busy2), 64'd1);
        @(negedge clk);
        chk("k1 restart done", 64'(done2), 64'd1);
        chk("k1 restart product", 64'(product2), 64'hFE01);
        @(negedge clk);
        chk("k1 idle", 64'(st2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
